// File: rtl/cf_math_pkg.sv
// Small math helpers shared by parameterised blocks.
package cf_math_pkg;

  // Bits needed to encode every value 0..num_idx. The extra headroom lets an
  // index one past the managed range be presented on an ID port, so that
  // out-of-range IDs can be detected instead of aliasing onto valid ones.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 1) ? unsigned'($clog2(num_idx + 1)) : 1;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter.
// MODE 0: cnt_o = index of the lowest set bit (trailing zeros).
// MODE 1: cnt_o = number of zeros above the highest set bit (leading zeros).
// empty_o is high when no input bit is set; cnt_o is then zero.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int W = int'(WIDTH);

  // Priority scan; the last match in scan order wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    cnt_o = '0;
    if (!MODE) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(unsigned'(i));
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(unsigned'(W - 1 - i));
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/id_free_list.sv
// Free-list allocator for transaction IDs. A bitmap tracks IDs that are free
// and not staged; the lowest free ID is staged behind a valid/ready handshake
// and IDs handed back by the consumer return to the pool.
module id_free_list
  import cf_math_pkg::*;
#(
  parameter int unsigned NUM_IDS   = 8,
  parameter int unsigned ID_WIDTH  = idx_width(NUM_IDS),
  parameter int unsigned CNT_WIDTH = $clog2(NUM_IDS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 alloc_valid_o,
  input  logic                 alloc_ready_i,
  output logic [ID_WIDTH-1:0]  alloc_id_o,
  input  logic                 release_valid_i,
  input  logic [ID_WIDTH-1:0]  release_id_i,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] free_cnt_o,
  output logic                 err_o
);

  localparam int unsigned       LZC_WIDTH   = $clog2(NUM_IDS);
  localparam logic [ID_WIDTH:0] NUM_IDS_EXT = (ID_WIDTH + 1)'(NUM_IDS);

  logic [NUM_IDS-1:0]   free_q, free_d;
  logic                 valid_q, valid_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic                 err_q, err_d;

  logic [LZC_WIDTH-1:0] lzc_cnt;
  logic                 lzc_empty;
  logic                 load;
  logic                 rel_in_range;
  logic                 rel_busy;
  logic                 rel_staged;
  logic                 rel_legal;

  // Lowest free (and not staged) ID.
  lzc #(
    .WIDTH (NUM_IDS),
    .MODE  (1'b0)
  ) u_lzc (
    .in_i    (free_q),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // The stage refills when it is empty or being drained, and an ID exists.
  assign load = (!valid_q || alloc_ready_i) && !lzc_empty && !flush_i;

  // A release is legal only for an in-range ID currently held by the consumer.
  always_comb begin
    rel_busy = 1'b0;
    for (int i = 0; i < int'(NUM_IDS); i++) begin
      if (release_id_i == ID_WIDTH'(i)) rel_busy = ~free_q[i];
    end
  end

  assign rel_in_range = {1'b0, release_id_i} < NUM_IDS_EXT;
  assign rel_staged   = valid_q && (id_q == release_id_i);
  assign rel_legal    = release_valid_i && rel_in_range && rel_busy && !rel_staged;

  // Next state: flush wins; otherwise release and load apply together.
  always_comb begin
    free_d  = free_q;
    valid_d = valid_q;
    id_d    = id_q;
    err_d   = err_q;
    if (flush_i) begin
      free_d  = '1;
      valid_d = 1'b0;
    end else begin
      if (release_valid_i && !rel_legal) err_d = 1'b1;
      for (int i = 0; i < int'(NUM_IDS); i++) begin
        if (rel_legal && (release_id_i == ID_WIDTH'(i))) free_d[i] = 1'b1;
        if (load && (lzc_cnt == LZC_WIDTH'(i)))          free_d[i] = 1'b0;
      end
      if (load) begin
        id_d    = ID_WIDTH'(lzc_cnt);
        valid_d = 1'b1;
      end else if (alloc_ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      free_q  <= '1;
      valid_q <= 1'b0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      free_q  <= free_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  // IDs not owned by the consumer: free bitmap ones plus the staged ID.
  always_comb begin
    free_cnt_o = CNT_WIDTH'(valid_q);
    for (int i = 0; i < int'(NUM_IDS); i++) begin
      free_cnt_o = free_cnt_o + CNT_WIDTH'(free_q[i]);
    end
  end

  assign alloc_valid_o = valid_q;
  assign alloc_id_o    = id_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_id_free_list.sv
// Self-checking bench for id_free_list: directed scenarios with literal
// expectations, then randomized traffic against an ownership-based model.
module tb_id_free_list;

  localparam int N   = 8;
  localparam int IDW = 4;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           ready;
  logic           rel_v;
  logic [IDW-1:0] rel_id;
  logic           flush;
  logic           alloc_valid;
  logic [IDW-1:0] alloc_id;
  logic [CW-1:0]  free_cnt;
  logic           err;

  always #5 clk = ~clk;

  id_free_list #(.NUM_IDS(N)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .alloc_valid_o   (alloc_valid),
    .alloc_ready_i   (ready),
    .alloc_id_o      (alloc_id),
    .release_valid_i (rel_v),
    .release_id_i    (rel_id),
    .flush_i         (flush),
    .free_cnt_o      (free_cnt),
    .err_o           (err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: which IDs the consumer holds, plus the staged ID.
  bit m_owned[N];
  bit m_valid;
  int m_id;
  bit m_err;
  bit cmp_en = 1'b0;

  function automatic int m_free_cnt();
    int c = N;
    for (int i = 0; i < N; i++) if (m_owned[i]) c--;
    return c;
  endfunction

  function automatic void model_step();
    int  lowest;
    bit  legal;
    bit  hs;
    if (rst) begin
      foreach (m_owned[i]) m_owned[i] = 1'b0;
      m_valid = 1'b0;
      m_id    = 0;
      m_err   = 1'b0;
      return;
    end
    if (flush) begin
      foreach (m_owned[i]) m_owned[i] = 1'b0;
      m_valid = 1'b0;
      return;
    end
    // Lowest ID neither held by the consumer nor staged, from pre-edge state.
    lowest = -1;
    for (int i = N - 1; i >= 0; i--)
      if (!m_owned[i] && !(m_valid && m_id == i)) lowest = i;
    legal = rel_v && (int'(rel_id) < N) && m_owned[int'(rel_id) % N];
    if (rel_v && !legal) m_err = 1'b1;
    hs = m_valid && ready;
    if (hs)    m_owned[m_id] = 1'b1;
    if (legal) m_owned[int'(rel_id)] = 1'b0;
    if ((!m_valid || ready) && lowest >= 0) begin
      m_id    = lowest;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endfunction

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", alloc_valid, m_valid);
      if (m_valid) check("m_id", alloc_id, m_id);
      check("m_cnt", free_cnt, m_free_cnt());
      check("m_err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic expect_state(input string name, input bit v, input int id,
                              input int cnt, input bit e);
    check({name, "_valid"}, alloc_valid, v);
    if (v) check({name, "_id"}, alloc_id, id);
    check({name, "_cnt"}, free_cnt, cnt);
    check({name, "_err"}, err, e);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rel_v = 1'b0;
    flush = 1'b0;
    tick();
    rst   = 1'b0;
    expect_state("reset", 1'b0, 0, N, 1'b0);
  endtask

  task automatic release_id(input int id);
    rel_v  = 1'b1;
    rel_id = IDW'(id);
    tick();
    rel_v  = 1'b0;
  endtask

  initial begin
    int q[$];
    rst = 1'b1; ready = 1'b0; rel_v = 1'b0; rel_id = '0; flush = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    expect_state("por", 1'b0, 0, N, 1'b0);
    rst = 1'b0;

    // First cycle after reset stages ID 0; stable while stalled.
    tick();
    expect_state("first", 1'b1, 0, 8, 1'b0);
    repeat (10) begin
      tick();
      expect_state("stall0", 1'b1, 0, 8, 1'b0);
    end

    // Back-to-back allocation of every ID, then exhaustion.
    ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      expect_state("seq", 1'b1, k, 8 - k, 1'b0);
      tick();
    end
    expect_state("exhaust", 1'b0, 0, 0, 1'b0);
    repeat (2) tick();
    expect_state("exhaust_hold", 1'b0, 0, 0, 1'b0);

    // Release 5 into an empty pool: count at t+1, staged at t+2.
    release_id(5);
    expect_state("rel5_t1", 1'b0, 0, 1, 1'b0);
    tick();
    expect_state("rel5_t2", 1'b1, 5, 1, 1'b0);
    tick();
    expect_state("rel5_taken", 1'b0, 0, 0, 1'b0);

    // Illegal: double release of ID 2.
    do_reset();
    ready = 1'b1;
    repeat (9) tick();
    expect_state("drain", 1'b0, 0, 0, 1'b0);
    ready = 1'b0;
    release_id(2);
    expect_state("rel2_ok", 1'b0, 0, 1, 1'b0);
    release_id(2);
    expect_state("rel2_dup", 1'b1, 2, 1, 1'b1);
    repeat (3) tick();
    expect_state("rel2_sticky", 1'b1, 2, 1, 1'b1);

    // Illegal: release of the staged ID; error survives a flush.
    do_reset();
    tick();
    expect_state("stage0", 1'b1, 0, 8, 1'b0);
    release_id(0);
    expect_state("rel_staged", 1'b1, 0, 8, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_state("flush_keeps_err", 1'b0, 0, 8, 1'b1);

    // Illegal: out-of-range ID 9.
    do_reset();
    tick();
    release_id(9);
    expect_state("rel9", 1'b1, 0, 8, 1'b1);

    // Flush with a same-cycle release: release ignored, no error.
    do_reset();
    tick();
    ready = 1'b1;
    repeat (3) tick();
    expect_state("three_out", 1'b1, 3, 5, 1'b0);
    ready  = 1'b0;
    flush  = 1'b1;
    rel_v  = 1'b1;
    rel_id = IDW'(1);
    tick();
    flush = 1'b0;
    rel_v = 1'b0;
    expect_state("flush_t1", 1'b0, 0, 8, 1'b0);
    tick();
    expect_state("flush_t2", 1'b1, 0, 8, 1'b0);

    // Releases while stalled; served lowest-first once ready.
    ready = 1'b1;
    repeat (4) tick();
    expect_state("four_out", 1'b1, 4, 4, 1'b0);
    ready = 1'b0;
    release_id(0);
    expect_state("stall_rel0", 1'b1, 4, 5, 1'b0);
    release_id(3);
    expect_state("stall_rel3", 1'b1, 4, 6, 1'b0);
    repeat (2) tick();
    expect_state("stall_hold", 1'b1, 4, 6, 1'b0);
    ready = 1'b1;
    tick();
    expect_state("serve0", 1'b1, 0, 5, 1'b0);
    tick();
    expect_state("serve3", 1'b1, 3, 4, 1'b0);
    tick();
    expect_state("serve5", 1'b1, 5, 3, 1'b0);

    // Randomized traffic, checked by the compare process.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      rel_v = ($urandom_range(0, 2) == 0);
      q.delete();
      for (int i = 0; i < N; i++) if (m_owned[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 15) != 0)
        rel_id = IDW'(q[$urandom_range(0, q.size() - 1)]);
      else
        rel_id = IDW'($urandom_range(0, 15));
      flush = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 255) == 0);
      tick();
    end
    rst = 1'b0; rel_v = 1'b0; flush = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
